// File: rtl/exu_seq_ctrl.sv
// exu_seq_ctrl: multi-cycle instruction sequencer for the NPC core.
// Each instruction is stepped through FETCH -> WAIT_RSP -> DECODE -> EXEC -> WB.
// The controller fetches the instruction, holds it and its PC for exu_decode,
// requests execution, commits writeback, then moves the PC on.
// It halts on ebreak, on a fetch bus error, or when a fetch response takes too long.
//
// Ports
//   clk, rst_n            core clock, asynchronous active-low reset
//   ifu_req_*             fetch request handshake (addr = pc)
//   ifu_rsp_*             fetch response handshake (err qualified by valid)
//   dec_instr, dec_pc_o   registered instruction / PC for the decoder
//   dec_ebreak            ebreak flag coming back from the decoder
//   exe_valid/ready/npc   execute handshake, exe_npc valid with exe_ready
//   wb_en                 one-cycle regfile write strobe
//   halt, halt_code       sticky halt, 0 none / 1 ebreak / 2 fetch err / 3 timeout
//   retire_cnt            retired instruction count (wraps)
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | present pc on the fetch request until memory accepts it
// WAIT_RSP | wait for the response, counting cycles toward the timeout
// DECODE   | one cycle of settle time for the decoder; check for ebreak
// EXEC     | hold exe_valid until execute reports done
// WB       | one-cycle writeback strobe, pc <- captured next pc
// HALT     | terminal until reset
module exu_seq_ctrl #(
  parameter int unsigned          PC_SIZE       = 32,
  parameter int unsigned          INSTR_SIZE    = 32,
  parameter logic [PC_SIZE-1:0]   RESET_PC      = PC_SIZE'(32'h8000_0000),
  parameter int unsigned          FETCH_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  input  logic                  ifu_rsp_err,
  output logic                  ifu_rsp_ready,
  output logic [INSTR_SIZE-1:0] dec_instr,
  output logic [PC_SIZE-1:0]    dec_pc_o,
  input  logic                  dec_ebreak,
  output logic                  exe_valid,
  input  logic                  exe_ready,
  input  logic [PC_SIZE-1:0]    exe_npc,
  output logic                  wb_en,
  output logic                  halt,
  output logic [1:0]            halt_code,
  output logic [31:0]           retire_cnt
);

  localparam int unsigned       TMO_W    = $clog2(FETCH_TIMEOUT + 1);
  // The halt decision is made in the last allowed waiting cycle, so a response
  // arriving in that cycle is still accepted.
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_RSP = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WB       = 3'd4,
    S_HALT     = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [PC_SIZE-1:0]      pc_q, pc_d;
  logic [PC_SIZE-1:0]      npc_q, npc_d;
  logic [INSTR_SIZE-1:0]   instr_q, instr_d;
  logic [PC_SIZE-1:0]      dec_pc_q, dec_pc_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [1:0]              halt_code_q, halt_code_d;
  logic [31:0]             retire_q, retire_d;
  logic                    req_valid_q, req_valid_d;
  logic                    rsp_ready_q, rsp_ready_d;
  logic                    exe_valid_q, exe_valid_d;
  logic                    wb_en_q, wb_en_d;
  logic                    halt_q, halt_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    instr_d     = instr_q;
    dec_pc_d    = dec_pc_q;
    tmo_d       = tmo_q;
    halt_code_d = halt_code_q;
    retire_d    = retire_q;

    case (state_q)
      S_FETCH: begin
        // Gate on the registered valid so nothing is accepted in the first
        // cycle after reset, while the request is still low.
        if (req_valid_q && ifu_req_ready) begin
          state_d = S_WAIT_RSP;
          tmo_d   = '0;
        end
      end
      S_WAIT_RSP: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d     = S_HALT;
            halt_code_d = 2'd2;
          end else begin
            state_d  = S_DECODE;
            instr_d  = ifu_rsp_instr;
            dec_pc_d = pc_q;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) begin
            state_d     = S_HALT;
            halt_code_d = 2'd3;
          end
        end
      end
      S_DECODE: begin
        if (dec_ebreak) begin
          state_d     = S_HALT;
          halt_code_d = 2'd1;
          retire_d    = retire_q + 32'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exe_ready) begin
          state_d = S_WB;
          npc_d   = exe_npc & ~PC_SIZE'(3);
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        pc_d     = npc_q;
        retire_d = retire_q + 32'd1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Strobes are registered decodes of the next state. This keeps every
    // output free of input-to-output paths and forces them all low in reset.
    req_valid_d = (state_d == S_FETCH);
    rsp_ready_d = (state_d == S_WAIT_RSP);
    exe_valid_d = (state_d == S_EXEC);
    wb_en_d     = (state_d == S_WB);
    halt_d      = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      npc_q       <= RESET_PC;
      instr_q     <= '0;
      dec_pc_q    <= RESET_PC;
      tmo_q       <= '0;
      halt_code_q <= 2'd0;
      retire_q    <= 32'd0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      exe_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      instr_q     <= instr_d;
      dec_pc_q    <= dec_pc_d;
      tmo_q       <= tmo_d;
      halt_code_q <= halt_code_d;
      retire_q    <= retire_d;
      req_valid_q <= req_valid_d;
      rsp_ready_q <= rsp_ready_d;
      exe_valid_q <= exe_valid_d;
      wb_en_q     <= wb_en_d;
      halt_q      <= halt_d;
    end
  end

  assign ifu_req_valid = req_valid_q;
  assign ifu_req_addr  = pc_q;
  assign ifu_rsp_ready = rsp_ready_q;
  assign dec_instr     = instr_q;
  assign dec_pc_o      = dec_pc_q;
  assign exe_valid     = exe_valid_q;
  assign wb_en         = wb_en_q;
  assign halt          = halt_q;
  assign halt_code     = halt_code_q;
  assign retire_cnt    = retire_q;

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Bench for exu_seq_ctrl: acts as fetch memory, decoder (ebreak detect) and
// execute unit. It tracks the architectural result of each instruction
// (pc, retire count, halt code, latched instruction) and the expected cycle cost.
module tb_exu_seq_ctrl;
  localparam int          FT     = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid, ifu_req_ready = 1'b0;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_instr = '0;
  logic        ifu_rsp_err = 1'b0;
  logic        ifu_rsp_ready;
  logic [31:0] dec_instr, dec_pc_o;
  logic        dec_ebreak;
  logic        exe_valid, exe_ready = 1'b0;
  logic [31:0] exe_npc = '0;
  logic        wb_en, halt;
  logic [1:0]  halt_code;
  logic [31:0] retire_cnt;

  exu_seq_ctrl #(
    .PC_SIZE(32), .INSTR_SIZE(32), .RESET_PC(RST_PC), .FETCH_TIMEOUT(FT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .ifu_rsp_ready(ifu_rsp_ready),
    .dec_instr(dec_instr), .dec_pc_o(dec_pc_o), .dec_ebreak(dec_ebreak),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_npc(exe_npc),
    .wb_en(wb_en), .halt(halt), .halt_code(halt_code), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Decoder stand-in.
  assign dec_ebreak = (dec_instr == EBREAK);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference state, updated once per instruction outcome.
  logic [31:0] m_pc, m_instr, m_dec_pc, m_retire;
  logic [1:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = '0; m_dec_pc = RST_PC; m_retire = '0; m_code = 2'd0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", ifu_req_valid, 0);
    chk("rst_rsp_ready", ifu_rsp_ready, 0);
    chk("rst_exe_valid", exe_valid, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halt_code", halt_code, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc_o, RST_PC);
    chk("rst_addr", ifu_req_addr, RST_PC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0; exe_ready = 0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_halted();
    for (int i = 0; i < 4; i++) begin
      chk("halt", halt, 1);
      chk("halt_code", halt_code, m_code);
      chk("halt_retire", retire_cnt, m_retire);
      chk("halt_dec_instr", dec_instr, m_instr);
      chk("halt_req_valid", ifu_req_valid, 0);
      chk("halt_rsp_ready", ifu_rsp_ready, 0);
      chk("halt_exe_valid", exe_valid, 0);
      chk("halt_wb_en", wb_en, 0);
      ifu_req_ready = 1'($urandom); ifu_rsp_valid = 1'($urandom);
      ifu_rsp_err = 1'($urandom); exe_ready = 1'($urandom);
      ifu_rsp_instr = $urandom; exe_npc = $urandom;
      @(negedge clk);
    end
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0; exe_ready = 0;
  endtask

  // One instruction. Returns halted=1 if the run ended in HALT.
  // When abort is set, reset is pulsed in EXEC and the instruction is dropped.
  task automatic run_instr(input logic [31:0] instr, input int req_dly, input int rsp_dly,
                           input bit err, input int exe_dly, input logic [31:0] npc,
                           input bit abort, output bit halted);
    int t0;
    bit ok;
    halted = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      chk("no_wb_in_fetch", wb_en, 0);
      if (ifu_req_valid) ok = 1;
      else @(negedge clk);
    end
    chk("fetch_seen", ok, 1);
    if (!ok) begin halted = 1; return; end
    t0 = cyc;
    chk("req_addr", ifu_req_addr, m_pc);
    for (int i = 0; i < req_dly; i++) begin
      ifu_req_ready = 0;
      @(negedge clk);
      chk("req_hold", ifu_req_valid, 1);
      chk("addr_hold", ifu_req_addr, m_pc);
    end
    ifu_req_ready = 1;
    @(negedge clk);
    ifu_req_ready = 0;
    chk("req_drop", ifu_req_valid, 0);
    for (int i = 0; i < rsp_dly && i < FT; i++) begin
      chk("rsp_ready_wait", ifu_rsp_ready, 1);
      @(negedge clk);
    end
    if (rsp_dly >= FT) begin
      m_code = 2'd3; halted = 1;
      check_halted();
      return;
    end
    chk("rsp_ready", ifu_rsp_ready, 1);
    ifu_rsp_valid = 1; ifu_rsp_instr = instr; ifu_rsp_err = err;
    @(negedge clk);
    ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_instr = $urandom;
    if (err) begin
      m_code = 2'd2; halted = 1;
      check_halted();
      return;
    end
    m_instr = instr; m_dec_pc = m_pc;
    chk("dec_instr", dec_instr, m_instr);
    chk("dec_pc", dec_pc_o, m_dec_pc);
    chk("decode_no_exe", exe_valid, 0);
    @(negedge clk);
    if (instr == EBREAK) begin
      m_retire = m_retire + 1; m_code = 2'd1; halted = 1;
      check_halted();
      return;
    end
    for (int i = 0; i < exe_dly; i++) begin
      chk("exe_hold", exe_valid, 1);
      chk("exe_no_wb", wb_en, 0);
      @(negedge clk);
    end
    chk("exe_valid", exe_valid, 1);
    if (abort) begin
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      return;
    end
    exe_ready = 1; exe_npc = npc;
    @(negedge clk);
    exe_ready = 0; exe_npc = $urandom;
    chk("wb_en", wb_en, 1);
    chk("wb_exe_low", exe_valid, 0);
    @(negedge clk);
    m_pc = npc & 32'hFFFF_FFFC;
    m_retire = m_retire + 1;
    chk("wb_once", wb_en, 0);
    chk("retire", retire_cnt, m_retire);
    chk("next_req_valid", ifu_req_valid, 1);
    chk("next_addr", ifu_req_addr, m_pc);
    chk("dec_stable", dec_instr, m_instr);
    chk("latency", cyc - t0, 5 + req_dly + rsp_dly + exe_dly);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit h;
    model_reset();
    do_reset();
    // zero-wait addi, then misaligned npc, then ebreak at 0x80000008
    run_instr(ADDI, 0, 0, 0, 0, RST_PC + 4, 0, h);
    chk("first_retire", retire_cnt, 1);
    run_instr(32'h0020_8133, 3, 0, 0, 0, 32'h8000_000B, 0, h);
    chk("aligned_pc", ifu_req_addr, 32'h8000_0008);
    run_instr(EBREAK, 0, 0, 0, 0, 32'h0, 0, h);
    chk("ebreak_halted", h, 1);
    // fetch error on the first response
    do_reset();
    run_instr(ADDI, 0, 1, 1, 0, 32'h0, 0, h);
    chk("err_halted", h, 1);
    // timeout, then a response on the last allowed waiting cycle
    do_reset();
    run_instr(ADDI, 0, FT, 0, 0, 32'h0, 0, h);
    do_reset();
    run_instr(ADDI, 0, FT - 1, 0, 1, RST_PC + 4, 0, h);
    chk("boundary_no_halt", halt, 0);
    // reset during EXEC, then a clean fetch from the reset PC
    do_reset();
    run_instr(ADDI, 1, 0, 0, 2, RST_PC + 4, 1, h);
    run_instr(ADDI, 0, 0, 0, 0, RST_PC + 8, 0, h);
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [31:0] ins;
      r = $urandom_range(0, 99);
      ins = (r < 6) ? EBREAK : $urandom;
      run_instr(ins,
                $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? FT + $urandom_range(0, 2) : $urandom_range(0, FT - 1),
                (r >= 6 && r < 9),
                $urandom_range(0, 3),
                $urandom,
                (r >= 9 && r < 11),
                h);
      if (h) do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exu_seq_ctrl.md
Name: exu_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the NPC core; steps each instruction through FETCH → DECODE → EXEC → WB.
- Drives the instruction-fetch handshake and holds the fetched instruction and its PC stable for exu_decode.
- Issues the execute request, commits writeback, updates the PC, and halts on ebreak, fetch error or fetch timeout.

Parameters:
- PC_SIZE, 32, PC and fetch-address width.
- INSTR_SIZE, 32, instruction width.
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- FETCH_TIMEOUT, 255, maximum wait cycles for a fetch response; must be at least 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  memory accepts the request.
- ifu_req_addr  out  PC_SIZE  fetch address (= pc).
- ifu_rsp_valid  in  1  fetch response valid.
- ifu_rsp_instr  in  INSTR_SIZE  fetched instruction.
- ifu_rsp_err  in  1  fetch bus error; qualified by ifu_rsp_valid.
- ifu_rsp_ready  out  1  controller accepts the response.
- dec_instr  out  INSTR_SIZE  registered instruction, feeds rv32_instr of exu_decode.
- dec_pc_o  out  PC_SIZE  registered PC, feeds i_pc of exu_decode.
- dec_ebreak  in  1  ebreak flag (DECINFO_ALU_EBRK qualified by DECINFO_GRP_ALU) from decoder output.
- exe_valid  out  1  execute request.
- exe_ready  in  1  execute done; exe_npc is valid.
- exe_npc  in  PC_SIZE  next PC from execute.
- wb_en  out  1  one-cycle regfile write strobe; gated externally with dec_rdwen.
- halt  out  1  core halted, sticky.
- halt_code  out  2  0 none, 1 ebreak, 2 fetch error, 3 timeout.
- retire_cnt  out  32  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - State = FETCH; pc = RESET_PC.
  - dec_instr = 0; dec_pc_o = RESET_PC.
  - halt = 0; halt_code = 0; retire_cnt = 0; timeout counter = 0.
  - All valid/strobe outputs low.
  - Reset asserted mid-operation aborts the in-flight instruction immediately; no writeback occurs.
- States: FETCH, WAIT_RSP, DECODE, EXEC, WB, HALT. All outputs are registered or decoded from state only; no input-to-output combinational path.
- FETCH:
  - ifu_req_valid = 1; ifu_req_addr = pc.
  - On ifu_req_ready → WAIT_RSP, timeout counter cleared.
  - ifu_req_valid stays high and ifu_req_addr stable until accepted.
- WAIT_RSP:
  - ifu_rsp_ready = 1.
  - On ifu_rsp_valid with err=0: latch dec_instr = ifu_rsp_instr and dec_pc_o = pc → DECODE.
  - On ifu_rsp_valid with err=1 → HALT, halt_code = 2; dec_instr unchanged.
  - Each cycle without ifu_rsp_valid increments the counter. When the counter equals FETCH_TIMEOUT and ifu_rsp_valid is still low → HALT, halt_code = 3.
  - A response arriving in the same cycle the counter reaches FETCH_TIMEOUT is accepted; the response wins.
- DECODE:
  - Exactly one cycle, giving the decoder a full cycle of settle time.
  - dec_ebreak = 1 → HALT, halt_code = 1; retire_cnt increments (ebreak retires).
  - Otherwise → EXEC.
- EXEC:
  - exe_valid = 1; held until exe_ready.
  - On exe_ready: capture next PC = exe_npc → WB.
  - exe_npc bits [1:0] are forced to 0 on capture.
- WB:
  - wb_en = 1 for exactly this one cycle.
  - pc = captured next PC; retire_cnt += 1 (wraps modulo 2^32) → FETCH.
- HALT:
  - Terminal until reset. halt = 1; halt_code held.
  - No fetch or exec requests; ifu_rsp_ready = 0.
  - Inputs are ignored.
- Latency: minimum 5 cycles per instruction (FETCH, WAIT_RSP, DECODE, EXEC, WB) with zero-wait memory and execute.
- dec_instr and dec_pc_o change only on acceptance of a fetch response.

Test Plan:
- Reset release, zero-wait memory, addi x1,x0,5 (0x00500093), exe_npc = pc+4 → ifu_req_addr = 0x80000000, then 0x80000004 exactly 5 cycles later; wb_en high 1 cycle; retire_cnt = 1.
- ifu_req_ready low 3 cycles → ifu_req_valid held, address stable at 0x80000000; response then accepted normally.
- ebreak (0x00100073) fetched at 0x80000008 → halt = 1, halt_code = 1, retire_cnt incremented, no wb_en pulse, no further ifu_req_valid.
- ifu_rsp_err = 1 on the first response → halt_code = 2, dec_instr stays 0, retire_cnt = 0.
- FETCH_TIMEOUT = 4, response never returns → halt_code = 3 after the counter reaches 4; second run with the response on exactly the 4th waiting cycle → accepted, no halt.
- rst_n pulsed low during EXEC → outputs immediately at reset values; next fetch from 0x80000000; no wb_en pulse.
